// File: rtl/regfile_wb_sched.sv
// Register-file writeback scheduler: keeps a busy scoreboard for issued
// destinations and arbitrates two writeback sources (A = ALU, B = memory)
// round-robin onto a single registered regfile write port.
module regfile_wb_sched (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        issue_valid_i,
    input  logic [2:0]  issue_dr_i,
    output logic        issue_ready_o,
    input  logic [2:0]  sr1_i,
    input  logic [2:0]  sr2_i,
    output logic        hazard_o,
    input  logic        req_a_i,
    input  logic        req_b_i,
    input  logic [2:0]  dr_a_i,
    input  logic [2:0]  dr_b_i,
    input  logic [15:0] data_a_i,
    input  logic [15:0] data_b_i,
    output logic        gnt_a_o,
    output logic        gnt_b_o,
    output logic        load_o,
    output logic [2:0]  dr_o,
    output logic [15:0] wr_data_o,
    output logic [7:0]  busy_o,
    output logic [3:0]  pend_cnt_o
);

    // Round-robin pointer values: which requester wins a contested cycle.
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    logic [7:0]  busy_q, busy_d;
    logic [3:0]  pend_cnt_q, pend_cnt_d;
    logic        load_q, load_d;
    logic [2:0]  dr_q, dr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        rr_q, rr_d;
    logic        issue_accept;

    assign issue_ready_o = ~busy_q[issue_dr_i];
    assign hazard_o      = busy_q[sr1_i] | busy_q[sr2_i];
    assign issue_accept  = issue_valid_i & issue_ready_o;

    // Same-cycle grant: a lone requester always wins, contention goes to the pointer.
    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        if (req_a_i && (!req_b_i || rr_q == RR_A)) begin
            gnt_a_o = 1'b1;
        end else if (req_b_i) begin
            gnt_b_o = 1'b1;
        end
    end

    // Next state for the write port, pointer and scoreboard.
    always_comb begin
        rr_d      = rr_q;
        load_d    = gnt_a_o | gnt_b_o;
        dr_d      = dr_q;
        wr_data_d = wr_data_q;
        if (gnt_a_o) begin
            rr_d      = RR_B;
            dr_d      = dr_a_i;
            wr_data_d = data_a_i;
        end else if (gnt_b_o) begin
            rr_d      = RR_A;
            dr_d      = dr_b_i;
            wr_data_d = data_b_i;
        end

        // Clear on the edge ending the Load cycle; an accepted issue is always
        // to a non-busy bit, so applying the set last never loses a pending write.
        busy_d = busy_q;
        if (load_q) begin
            busy_d[dr_q] = 1'b0;
        end
        if (issue_accept) begin
            busy_d[issue_dr_i] = 1'b1;
        end

        pend_cnt_d = '0;
        for (int i = 0; i < 8; i++) begin
            pend_cnt_d = pend_cnt_d + {3'b000, busy_d[i]};
        end
    end

    // State registers; reset discards any in-flight grant or issue.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
            load_q     <= 1'b0;
            dr_q       <= '0;
            wr_data_q  <= '0;
            rr_q       <= RR_A;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
            load_q     <= load_d;
            dr_q       <= dr_d;
            wr_data_q  <= wr_data_d;
            rr_q       <= rr_d;
        end
    end

    assign load_o     = load_q;
    assign dr_o       = dr_q;
    assign wr_data_o  = wr_data_q;
    assign busy_o     = busy_q;
    assign pend_cnt_o = pend_cnt_q;

endmodule
